// File: rtl/riscv_ppreg_hs.sv
// -----------------------------------------------------------------------------
// riscv_ppreg_hs
// Handshaked pipeline-stage register with a one-entry skid buffer.
// It carries an opaque DATA_W payload from one pipeline stage to the next.
// Upstream ready comes straight from a flop, so no combinational path runs
// from i_riscv_ppreg_ready to o_riscv_ppreg_ready. The second entry (skid)
// absorbs the beat that is already in flight when the stage stops draining.
//
// Ports:
//   i_riscv_ppreg_clk        rising-edge clock
//   i_riscv_ppreg_rst        synchronous active-high reset (clears all state)
//   i_riscv_ppreg_flush      kill held entries and drop any concurrent beat
//   i_riscv_ppreg_stall      hazard stall; blocks downstream transfer only
//   i_riscv_ppreg_valid      upstream payload valid
//   o_riscv_ppreg_ready      upstream may transfer (registered)
//   i_riscv_ppreg_data       upstream payload
//   o_riscv_ppreg_valid      downstream payload valid
//   i_riscv_ppreg_ready      downstream accepts
//   o_riscv_ppreg_data       downstream payload (zero in bubbles if BUBBLE_ZERO)
//   o_riscv_ppreg_count      entries held (0..2), registered
//   i_riscv_ppreg_cnt_clr    clear the stall-cycle counter
//   o_riscv_ppreg_stall_cnt  saturating count of cycles a held beat did not leave
// -----------------------------------------------------------------------------
module riscv_ppreg_hs #(
    parameter int unsigned DATA_W      = 64,
    parameter bit          BUBBLE_ZERO = 1'b1,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              i_riscv_ppreg_clk,
    input  logic              i_riscv_ppreg_rst,
    input  logic              i_riscv_ppreg_flush,
    input  logic              i_riscv_ppreg_stall,
    input  logic              i_riscv_ppreg_valid,
    output logic              o_riscv_ppreg_ready,
    input  logic [DATA_W-1:0] i_riscv_ppreg_data,
    output logic              o_riscv_ppreg_valid,
    input  logic              i_riscv_ppreg_ready,
    output logic [DATA_W-1:0] o_riscv_ppreg_data,
    output logic [1:0]        o_riscv_ppreg_count,
    input  logic              i_riscv_ppreg_cnt_clr,
    output logic [CNT_W-1:0]  o_riscv_ppreg_stall_cnt
);

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + 1'b1;
    endfunction

    logic              main_v_q, main_v_d;
    logic              skid_v_q, skid_v_d;
    logic [DATA_W-1:0] main_d_q, main_d_d;
    logic [DATA_W-1:0] skid_d_q, skid_d_d;
    logic              ready_q, ready_d;
    logic [1:0]        count_q, count_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic in_xfer;
    logic out_xfer;

    assign in_xfer  = i_riscv_ppreg_valid & ready_q;
    assign out_xfer = main_v_q & i_riscv_ppreg_ready & ~i_riscv_ppreg_stall;

    always_comb begin
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        main_d_d = main_d_q;
        skid_d_d = skid_d_q;

        if (i_riscv_ppreg_flush) begin
            // Flush wins over any handshake in the same cycle.
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
            main_d_d = '0;
            skid_d_d = '0;
        end else if (!main_v_q) begin
            // EMPTY
            if (in_xfer) begin
                main_v_d = 1'b1;
                main_d_d = i_riscv_ppreg_data;
            end
        end else if (!skid_v_q) begin
            // ONE
            if (in_xfer && out_xfer) begin
                main_d_d = i_riscv_ppreg_data;
            end else if (out_xfer) begin
                main_v_d = 1'b0;
            end else if (in_xfer) begin
                skid_v_d = 1'b1;
                skid_d_d = i_riscv_ppreg_data;
            end
        end else begin
            // FULL: ready is low, so only the drain side can move.
            if (out_xfer) begin
                main_d_d = skid_d_q;
                skid_v_d = 1'b0;
            end
        end

        // Bubbles present an all-zero payload so legacy decoders see a NOP.
        if (BUBBLE_ZERO && !main_v_d) begin
            main_d_d = '0;
        end

        ready_d = ~skid_v_d;
        count_d = {1'b0, main_v_d} + {1'b0, skid_v_d};

        stall_cnt_d = stall_cnt_q;
        if (i_riscv_ppreg_cnt_clr) begin
            stall_cnt_d = '0;
        end else if (main_v_q && !out_xfer && !i_riscv_ppreg_flush) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end
    end

    always_ff @(posedge i_riscv_ppreg_clk) begin
        if (i_riscv_ppreg_rst) begin
            main_v_q    <= 1'b0;
            skid_v_q    <= 1'b0;
            main_d_q    <= '0;
            skid_d_q    <= '0;
            ready_q     <= 1'b1;
            count_q     <= 2'd0;
            stall_cnt_q <= '0;
        end else begin
            main_v_q    <= main_v_d;
            skid_v_q    <= skid_v_d;
            main_d_q    <= main_d_d;
            skid_d_q    <= skid_d_d;
            ready_q     <= ready_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_riscv_ppreg_ready     = ready_q;
    assign o_riscv_ppreg_valid     = main_v_q;
    assign o_riscv_ppreg_data      = main_d_q;
    assign o_riscv_ppreg_count     = count_q;
    assign o_riscv_ppreg_stall_cnt = stall_cnt_q;

endmodule
